spi_cmd_dispatch: RTL and testbench
===================================

SPI_CMD_DISPATCH -- requirements
Module: spi_cmd_dispatch

Interface
REQ-001 Parameter WB_ADDR_WIDTH, default 17, Wishbone address width.
REQ-002 Parameter DATA_WIDTH, default 8, SPI byte and Wishbone data width.
REQ-003 clk_i  in  1  system clock; the block has one clock.
REQ-004 reset_ni  in  1  asynchronous, active-low reset.
REQ-005 spi_cs_ni  in  1  SPI chip select, asynchronous to clk_i; high means no transfer.
REQ-006 spi_cycle_i  in  1  byte-complete strobe from the SPI core, in the SCK domain.
REQ-007 spi_data_i  in  DATA_WIDTH  received byte from the SPI core, in the SCK domain.
REQ-008 spi_data_o  out  DATA_WIDTH  next transmit byte to the SPI core.
REQ-009 wb_adr_o  out  WB_ADDR_WIDTH  Wishbone address.
REQ-010 wb_dat_o / wb_dat_i  out / in  DATA_WIDTH  Wishbone write data / read data.
REQ-011 wb_we_o, wb_cyc_o, wb_stb_o  out  1 each  Wishbone classic master controls.
REQ-012 wb_ack_i  in  1  Wishbone acknowledge.
REQ-013 overrun_o  out  1  sticky flag: a byte arrived while a Wishbone access was pending.

Function
REQ-014 The CDC path SHALL use the following mechanism:
  - On each rising spi_cycle_i edge, capture spi_data_i into a holding register and flip a toggle bit, both in the SCK domain.
  - Pass the toggle through a 2-flop synchronizer, then an edge detector, producing a 1-cycle byte_stb in the clk_i domain.
REQ-015 byte_stb SHALL assert 3 to 4 clk_i cycles after the spi_cycle_i rising edge.
REQ-016 The holding register SHALL be sampled in the same cycle as byte_stb.
REQ-017 spi_cs_ni SHALL be 2-flop synchronized to cs_sync.
REQ-018 The block SHALL support SCK rates up to clk_i/8.
REQ-019 The command byte SHALL be decoded as follows:
  - [7:5] = op: 000 WRITE, 001 READ, 010 WRITE_INC, 011 READ_INC; all other values are ILLEGAL.
  - [0] = address bit 16.
  - [4:1] are ignored.
REQ-020 The FSM states SHALL be CMD, ADDR_HI, ADDR_LO, DUMMY, DATA, DISCARD.
REQ-021 Each byte_stb SHALL advance the FSM as follows:
  - CMD -> ADDR_HI, or DISCARD if op is ILLEGAL.
  - ADDR_HI -> ADDR_LO.
  - ADDR_LO -> DUMMY for reads, DATA for writes.
  - DUMMY -> DATA.
  - DATA -> DATA.
  - DISCARD -> DISCARD.
REQ-022 A byte received in DATA SHALL start a Wishbone write of that byte to the current address.
REQ-023 Entering DUMMY SHALL start a Wishbone read of the current address.
REQ-024 Each byte received in DATA for READ_INC SHALL start a Wishbone read of the next address.
REQ-025 The address SHALL increment by 1 after each completed access for the _INC ops only.
REQ-026 The address SHALL wrap from 2^WB_ADDR_WIDTH-1 to 0.
REQ-027 For WRITE and READ, all bytes after the first data access SHALL be ignored and SHALL start no further accesses.
REQ-028 Wishbone access rules:
  - Assert cyc and stb together.
  - Hold wb_adr_o, wb_dat_o and wb_we_o stable until the wb_ack_i cycle.
  - Deassert cyc and stb in the cycle after the wb_ack_i cycle.
  - Allow at most one outstanding access.
REQ-029 On a read ack, the block SHALL register wb_dat_i into spi_data_o in the ack cycle.
REQ-030 spi_data_o SHALL otherwise hold its value.
REQ-031 A Wishbone access SHALL complete within 8 SCK periods so that the result is ready for the next byte.
REQ-032 If byte_stb arrives while an access is pending:
  - set overrun_o;
  - drop the byte;
  - keep the pending access running.
REQ-033 overrun_o SHALL clear only on reset or on the next CMD byte.
REQ-034 When cs_sync rises, the FSM SHALL go to CMD in the same cycle, from any state.
REQ-035 If an access is in flight when cs_sync rises, that access SHALL run to ack.
REQ-036 Simultaneous cs_sync rise and byte_stb: cs_sync wins and the byte is discarded.
REQ-037 The CDC toggle SHALL NOT be cleared by CS.

Reset
REQ-038 While reset_ni is low, the block SHALL hold these values:
  - FSM = CMD;
  - wb_cyc_o = wb_stb_o = wb_we_o = 0;
  - wb_adr_o = 0 and wb_dat_o = 0;
  - spi_data_o = 0 and overrun_o = 0;
  - synchronizer and edge-detect flops = 0.
REQ-039 Asserting reset mid-access SHALL abort the access immediately by dropping cyc/stb asynchronously.
REQ-040 The SCK-domain toggle and holding register SHALL also reset asynchronously on reset_ni.

Structure
REQ-041 Package spi_pkg SHALL hold:
  - the op enum spi_op_t (WRITE, READ, WRITE_INC, READ_INC);
  - the bit positions of op and A16 within the command byte;
  - the default WB_ADDR_WIDTH and DATA_WIDTH.
REQ-042 The SCK-domain capture, toggle, synchronizer and edge detector SHALL be one sub-module, spi_byte_cdc, instantiated once.

Verification
REQ-043 Bytes 0x01,0x23,0x45,0xA5 with ack after 2 cycles -> exactly one write with adr=0x12345, dat=0xA5, we=1; then cyc=0.
REQ-044 Bytes 0x60,0xFF,0xFF,0x00,0x00,0x00 with mem[0x0FFFF]=0x11 and mem[0x10000]=0x22 -> reads at 0x0FFFF then 0x10000; spi_data_o=0x11, then 0x22.
REQ-045 Bytes 0x61,0xFF,0xFF, two dummies -> reads at 0x1FFFF then 0x00000 (wrap).
REQ-046 Bytes 0xE0 then 5 further bytes -> no Wishbone activity; after a CS high pulse, 0x00,0x00,0x10,0x77 -> write of 0x77 to 0x00010.
REQ-047 Burst write with wb_ack_i delayed 20 SCK periods -> overrun_o=1 and the second byte is not written; the next command byte clears overrun_o.
REQ-048 reset_ni low while stb=1 -> cyc and stb = 0 immediately; after release, FSM = CMD and the next full command executes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: command-byte layout, op and FSM types and default widths shared by the SPI command dispatcher.
package spi_pkg;
    localparam int DEF_WB_ADDR_WIDTH = 17;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int OP_MSB            = 7;
    localparam int OP_LSB            = 5;
    localparam int A16_BIT           = 0;
    typedef enum logic [2:0] {
        WRITE     = 3'b000,
        READ      = 3'b001,
        WRITE_INC = 3'b010,
        READ_INC  = 3'b011
    } spi_op_t;
    typedef enum logic [2:0] {CMD, ADDR_HI, ADDR_LO, DUMMY, DATA, DISCARD} state_t;
    function automatic logic op_legal(input logic [2:0] op);
        return !op[2];
    endfunction
    function automatic logic op_read(input spi_op_t op);
        return op[0];
    endfunction
    function automatic logic op_inc(input spi_op_t op);
        return op[1];
    endfunction
endpackage

// File: rtl/spi_cmd_dispatch_if.sv
// spi_cmd_dispatch_if: Wishbone classic bus between the dispatcher (master) and its slave.
interface spi_cmd_dispatch_if
    import spi_pkg::*;
#(
    parameter int AW = DEF_WB_ADDR_WIDTH,
    parameter int DW = DEF_DATA_WIDTH
);
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i;
    logic          we;
    logic          cyc;
    logic          stb;
    logic          ack;
    modport master (output adr, dat_o, we, cyc, stb, input dat_i, ack);
    modport slave  (input adr, dat_o, we, cyc, stb, output dat_i, ack);
endinterface

// File: rtl/spi_byte_cdc.sv
// spi_byte_cdc: captures each SPI byte in the SCK domain and hands it to clk_i as a one-cycle strobe.
module spi_byte_cdc
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  spi_cycle_i,
    input  logic [DATA_WIDTH-1:0] spi_data_i,
    output logic                  byte_stb_o,
    output logic [DATA_WIDTH-1:0] byte_data_o
);
    logic                  tog_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  s1_q, s2_q, s3_q, stb_q;
    always_ff @(posedge spi_cycle_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tog_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            tog_q  <= ~tog_q;
            hold_q <= spi_data_i;
        end
    end
    // hold_q is quiet for many clk_i cycles around the strobe, so it is read directly
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            stb_q <= 1'b0;
        end else begin
            s1_q  <= tog_q;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            stb_q <= s2_q ^ s3_q;
        end
    end
    assign byte_stb_o  = stb_q;
    assign byte_data_o = hold_q;
endmodule

// File: rtl/spi_cmd_dispatch.sv
// spi_cmd_dispatch: decodes SPI command/address/data bytes into Wishbone classic reads and writes.
module spi_cmd_dispatch
    import spi_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = DEF_WB_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  spi_cs_ni,
    input  logic                  spi_cycle_i,
    input  logic [DATA_WIDTH-1:0] spi_data_i,
    output logic [DATA_WIDTH-1:0] spi_data_o,
    output logic                  overrun_o,
    spi_cmd_dispatch_if.master    wb
);
    logic                     byte_stb;
    logic [DATA_WIDTH-1:0]    rx;
    logic                     cs1_q, cs_sync_q, cs_prev_q;
    logic                     cs_rise, take;
    logic [2:0]               cmd_op;
    state_t                   state_q, state_d;
    spi_op_t                  op_q, op_d;
    logic                     a16_q, a16_d;
    logic [DATA_WIDTH-1:0]    hi_q, hi_d, dat_q, dat_d, rdat_q, rdat_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                     we_q, we_d, cyc_q, cyc_d, done_q, done_d, ovr_q, ovr_d;

    spi_byte_cdc #(.DATA_WIDTH(DATA_WIDTH)) u_cdc (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .spi_cycle_i (spi_cycle_i),
        .spi_data_i  (spi_data_i),
        .byte_stb_o  (byte_stb),
        .byte_data_o (rx)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cs1_q     <= 1'b0;
            cs_sync_q <= 1'b0;
            cs_prev_q <= 1'b0;
        end else begin
            cs1_q     <= spi_cs_ni;
            cs_sync_q <= cs1_q;
            cs_prev_q <= cs_sync_q;
        end
    end

    assign cs_rise = cs_sync_q & ~cs_prev_q;
    // a byte landing while an access is pending is dropped, never queued
    assign take    = byte_stb & ~cs_rise & ~cyc_q;
    assign cmd_op  = rx[OP_MSB:OP_LSB];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a16_d   = a16_q;
        hi_d    = hi_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        rdat_d  = rdat_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        if (cyc_q && wb.ack) begin
            cyc_d  = 1'b0;
            rdat_d = we_q ? rdat_q : wb.dat_i;
            adr_d  = op_inc(op_q) ? adr_q + WB_ADDR_WIDTH'(1) : adr_q;
        end
        if (byte_stb && cyc_q && !cs_rise)
            ovr_d = 1'b1;
        if (cs_rise)
            state_d = CMD;
        else if (take) begin
            case (state_q)
                CMD: begin
                    state_d = op_legal(cmd_op) ? ADDR_HI : DISCARD;
                    op_d    = op_legal(cmd_op) ? spi_op_t'(cmd_op) : op_q;
                    a16_d   = rx[A16_BIT];
                    done_d  = 1'b0;
                    ovr_d   = 1'b0;
                end
                ADDR_HI: begin
                    hi_d    = rx;
                    state_d = ADDR_LO;
                end
                ADDR_LO: begin
                    adr_d   = WB_ADDR_WIDTH'({a16_q, hi_q, rx});
                    state_d = op_read(op_q) ? DUMMY : DATA;
                    if (op_read(op_q)) begin
                        cyc_d  = 1'b1;
                        we_d   = 1'b0;
                        done_d = 1'b1;
                    end
                end
                DUMMY: state_d = DATA;
                DATA: if (!done_q || op_inc(op_q)) begin
                    cyc_d  = 1'b1;
                    we_d   = !op_read(op_q);
                    dat_d  = op_read(op_q) ? dat_q : rx;
                    done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= CMD;
            op_q    <= WRITE;
            a16_q   <= 1'b0;
            hi_q    <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rdat_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a16_q   <= a16_d;
            hi_q    <= hi_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rdat_q  <= rdat_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign wb.adr     = adr_q;
    assign wb.dat_o   = dat_q;
    assign wb.we      = we_q;
    assign wb.cyc     = cyc_q;
    assign wb.stb     = cyc_q;
    assign spi_data_o = rdat_q;
    assign overrun_o  = ovr_q;
endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// tb_spi_cmd_dispatch: directed SPI command streams checked against a bench model of the expected Wishbone traffic.
`define CHK(n, a, r) chk(n, 32'(a), 32'(r))
module tb_spi_cmd_dispatch;
    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b1;
    logic       spi_cs_ni = 1'b1;
    logic       spi_cycle_i = 1'b0;
    logic [7:0] spi_data_i = 8'h00;
    logic [7:0] spi_data_o;
    logic       overrun_o;

    spi_cmd_dispatch_if #(.AW(17), .DW(8)) wb();

    spi_cmd_dispatch dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .spi_cs_ni   (spi_cs_ni),
        .spi_cycle_i (spi_cycle_i),
        .spi_data_i  (spi_data_i),
        .spi_data_o  (spi_data_o),
        .overrun_o   (overrun_o),
        .wb          (wb)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [16:0] adr;
        logic        we;
        logic [7:0]  dat;
    } acc_t;

    acc_t        exp_q[$];
    logic [7:0]  mem [0:131071];
    logic [7:0]  tx[$];
    logic [16:0] rd_log[$];
    int          checks = 0;
    int          failures = 0;
    int          n_acc = 0;
    int          ack_dly = 2;
    logic [7:0]  exp_sdo = 8'h00;
    logic [16:0] last_adr = '0;
    logic [7:0]  last_dat = '0;
    logic        last_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected Wishbone traffic of one complete command, from the command-byte rules alone
    task automatic plan();
        logic [2:0]  op;
        logic [16:0] base;
        int          n;
        op = tx[0][7:5];
        if (op[2] || tx.size() < 3) return;
        base = {tx[0][0], tx[1], tx[2]};
        if (op[0]) n = (op[1] && tx.size() > 4) ? tx.size() - 3 : 1;
        else       n = (tx.size() < 4) ? 0 : (op[1] ? tx.size() - 3 : 1);
        for (int k = 0; k < n; k++) begin
            acc_t e;
            e.adr = base + 17'(k);
            e.we  = !op[0];
            e.dat = op[0] ? mem[e.adr] : tx[3+k];
            exp_q.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_i);
        #3 spi_data_i = b;
        #10 spi_cycle_i = 1'b1;
        #100 spi_cycle_i = 1'b0;
        repeat (80) @(posedge clk_i);
    endtask

    task automatic run_txn();
        plan();
        foreach (tx[i]) send_byte(tx[i]);
    endtask

    task automatic cs_pulse();
        @(posedge clk_i);
        #3 spi_cs_ni = 1'b1;
        repeat (8) @(posedge clk_i);
        #3 spi_cs_ni = 1'b0;
        repeat (8) @(posedge clk_i);
    endtask

    // Wishbone slave: acks after ack_dly cycles and scores every access against the model
    initial begin
        int          wcnt;
        logic [16:0] s_adr;
        logic [7:0]  s_dat;
        logic        s_we, cur_we;
        logic [7:0]  cur_rd;
        acc_t        e;
        wcnt = 0;
        cur_we = 1'b1;
        cur_rd = 8'h00;
        wb.ack = 1'b0;
        wb.dat_i = 8'h00;
        forever begin
            @(posedge clk_i);
            #1;
            if (wb.ack) begin
                wb.ack = 1'b0;
                wcnt = 0;
                `CHK("cyc_drop_after_ack", wb.cyc, 1'b0);
                if (!cur_we) exp_sdo = cur_rd;
            end else if (wb.cyc) begin
                if (wcnt == 0) begin
                    s_adr = wb.adr;
                    s_dat = wb.dat_o;
                    s_we  = wb.we;
                end
                wcnt++;
                if (wcnt >= ack_dly) begin
                    wb.ack = 1'b1;
                    `CHK("adr_stable", wb.adr, s_adr);
                    `CHK("dat_o_stable", wb.dat_o, s_dat);
                    `CHK("we_stable", wb.we, s_we);
                    n_acc++;
                    last_adr = wb.adr;
                    last_dat = wb.dat_o;
                    last_we  = wb.we;
                    if (wb.we) mem[wb.adr] = wb.dat_o;
                    else begin
                        wb.dat_i = mem[wb.adr];
                        rd_log.push_back(wb.adr);
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        cur_we = 1'b1;
                        $display("FAIL unexpected_access actual adr=0x%0h we=%0b required=no access", wb.adr, wb.we);
                    end else begin
                        e = exp_q.pop_front();
                        `CHK("acc_adr", wb.adr, e.adr);
                        `CHK("acc_we", wb.we, e.we);
                        if (e.we) `CHK("acc_dat", wb.dat_o, e.dat);
                        cur_we = e.we;
                        cur_rd = e.dat;
                    end
                end
            end else wcnt = 0;
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            `CHK("stb_eq_cyc", wb.stb, wb.cyc);
            `CHK("spi_data_o", spi_data_o, exp_sdo);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0;
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        #2 reset_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        `CHK("rst_cyc", wb.cyc, 1'b0);
        `CHK("rst_stb", wb.stb, 1'b0);
        `CHK("rst_we", wb.we, 1'b0);
        `CHK("rst_adr", wb.adr, 17'h0);
        `CHK("rst_dat_o", wb.dat_o, 8'h00);
        `CHK("rst_spi_data_o", spi_data_o, 8'h00);
        `CHK("rst_overrun", overrun_o, 1'b0);
        @(posedge clk_i);
        #3 reset_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        cs_pulse();

        a0 = n_acc;
        tx = '{8'h01, 8'h23, 8'h45, 8'hA5};
        run_txn();
        `CHK("w_count", n_acc - a0, 1);
        `CHK("w_adr", last_adr, 17'h12345);
        `CHK("w_dat", last_dat, 8'hA5);
        `CHK("w_we", last_we, 1'b1);
        `CHK("w_cyc_idle", wb.cyc, 1'b0);

        mem[17'h0FFFF] = 8'h11;
        mem[17'h10000] = 8'h22;
        mem[17'h10001] = 8'h33;
        cs_pulse();
        r0 = rd_log.size();
        tx = '{8'h60, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        plan();
        for (int i = 0; i < 3; i++) send_byte(tx[i]);
        `CHK("ri_first_data", spi_data_o, 8'h11);
        send_byte(tx[3]);
        send_byte(tx[4]);
        `CHK("ri_second_data", spi_data_o, 8'h22);
        send_byte(tx[5]);
        `CHK("ri_third_data", spi_data_o, 8'h33);
        `CHK("ri_count", rd_log.size() - r0, 3);
        `CHK("ri_adr0", rd_log[r0], 17'h0FFFF);
        `CHK("ri_adr1", rd_log[r0+1], 17'h10000);

        mem[17'h1FFFF] = 8'h5A;
        mem[17'h00000] = 8'hC3;
        cs_pulse();
        r0 = rd_log.size();
        tx = '{8'h61, 8'hFF, 8'hFF, 8'h00, 8'h00};
        run_txn();
        `CHK("wrap_count", rd_log.size() - r0, 2);
        `CHK("wrap_adr0", rd_log[r0], 17'h1FFFF);
        `CHK("wrap_adr1", rd_log[r0+1], 17'h00000);
        `CHK("wrap_data", spi_data_o, 8'hC3);

        cs_pulse();
        a0 = n_acc;
        tx = '{8'hE0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_txn();
        `CHK("illegal_no_access", n_acc - a0, 0);
        cs_pulse();
        tx = '{8'h00, 8'h00, 8'h10, 8'h77};
        run_txn();
        `CHK("after_cs_adr", last_adr, 17'h00010);
        `CHK("after_cs_dat", last_dat, 8'h77);
        `CHK("after_cs_mem", mem[17'h00010], 8'h77);

        cs_pulse();
        ack_dly = 200;
        a0 = n_acc;
        exp_q.push_back('{17'h00020, 1'b1, 8'hAA});
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'hAA);
        send_byte(8'hBB);
        `CHK("ovr_set", overrun_o, 1'b1);
        `CHK("ovr_access_kept", wb.cyc, 1'b1);
        for (int i = 0; i < 400 && wb.cyc; i++) @(posedge clk_i);
        #1;
        `CHK("ovr_ack_timeout", wb.cyc, 1'b0);
        `CHK("ovr_count", n_acc - a0, 1);
        `CHK("ovr_dropped", mem[17'h00021], 8'h00);
        ack_dly = 2;
        cs_pulse();
        `CHK("ovr_sticky_cs", overrun_o, 1'b1);
        send_byte(8'h00);
        `CHK("ovr_clear_cmd", overrun_o, 1'b0);

        ack_dly = 1000;
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h99);
        `CHK("abort_cyc_pending", wb.cyc, 1'b1);
        `CHK("abort_stb_pending", wb.stb, 1'b1);
        @(posedge clk_i);
        #3 reset_ni = 1'b0;
        exp_sdo = 8'h00;
        exp_q.delete();
        #1;
        `CHK("abort_cyc", wb.cyc, 1'b0);
        `CHK("abort_stb", wb.stb, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        `CHK("abort_adr", wb.adr, 17'h0);
        `CHK("abort_dat_o", wb.dat_o, 8'h00);
        `CHK("abort_overrun", overrun_o, 1'b0);
        @(posedge clk_i);
        #3 reset_ni = 1'b1;
        ack_dly = 2;
        repeat (4) @(posedge clk_i);
        a0 = n_acc;
        tx = '{8'h01, 8'h23, 8'h45, 8'h5C};
        run_txn();
        `CHK("post_rst_count", n_acc - a0, 1);
        `CHK("post_rst_adr", last_adr, 17'h12345);
        `CHK("post_rst_dat", last_dat, 8'h5C);
        `CHK("expected_all_seen", exp_q.size(), 0);
        `CHK("aborted_not_written", mem[17'h00005], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
